// File: rtl/user_wb_slave_arbiter_if.sv
// Bundles the management-side Wishbone slave port with the three downstream
// slave windows it is sequenced onto (shared adr/dat/sel pass straight through).
interface user_wb_slave_arbiter_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [2:0]  s_cyc_o;
    logic [2:0]  s_ack_i;
    logic [95:0] s_dat_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o, s_cyc_o,
        input  s_ack_i, s_dat_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o, s_cyc_o,
        output s_ack_i, s_dat_i
    );
endinterface

// File: rtl/user_wb_slave_arbiter.sv
// User-area Wishbone slave sequencer: decodes debug / GPIO-test / user windows,
// one downstream cyc per transfer. Define WB_TIMEOUT_EN to add the ack watchdog.
module user_wb_slave_arbiter #(
    parameter logic [31:0] S1_BASE        = 32'h3000_0000,
    parameter logic [31:0] S1_MASK        = 32'hFFFF_F000,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    user_wb_slave_arbiter_if.slave         bus,
    output logic                           timeout_flag,
    output logic [7:0]                     timeout_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [1:0]  sel_q;
    logic [1:0]  dec_idx;
    logic        sel_ack;
    logic [31:0] sel_dat;
    logic        to_fire;

    // Debug pair outranks the GPIO window, which outranks the user default.
    always_comb begin
        dec_idx = 2'd0;
        if (bus.wbs_adr_i[31:3] == 29'h601FFFF)
            dec_idx = 2'd2;
        else if ((bus.wbs_adr_i & S1_MASK) == (S1_BASE & S1_MASK))
            dec_idx = 2'd1;
    end

    assign sel_ack = bus.s_ack_i[sel_q];
    assign sel_dat = bus.s_dat_i[{sel_q, 5'd0} +: 32];

`ifdef WB_TIMEOUT_EN
    logic [7:0] wd_q;

    // A real ack in the expiry cycle takes precedence over the timeout.
    assign to_fire = (state == BUSY) && bus.wbs_cyc_i && !sel_ack &&
                     (wd_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wd_q         <= 8'd0;
            timeout_flag <= 1'b0;
            timeout_cnt  <= 8'd0;
        end else begin
            wd_q <= (state == BUSY) ? wd_q + 8'd1 : 8'd0;
            if (to_fire) begin
                timeout_flag <= 1'b1;
                if (timeout_cnt != 8'hFF)
                    timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end
`else
    assign to_fire      = 1'b0;
    assign timeout_flag = 1'b0;
    assign timeout_cnt  = 8'd0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            sel_q         <= 2'd0;
            bus.s_cyc_o   <= 3'b000;
            bus.wbs_ack_o <= 1'b0;
            bus.wbs_dat_o <= 32'd0;
        end else begin
            bus.wbs_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                        sel_q       <= dec_idx;
                        bus.s_cyc_o <= 3'b001 << dec_idx;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // Master abort beats a same-cycle slave ack.
                    if (!bus.wbs_cyc_i) begin
                        bus.s_cyc_o <= 3'b000;
                        state       <= IDLE;
                    end else if (sel_ack) begin
                        bus.wbs_dat_o <= sel_dat;
                        bus.wbs_ack_o <= 1'b1;
                        bus.s_cyc_o   <= 3'b000;
                        state         <= DONE;
                    end else if (to_fire) begin
                        bus.wbs_dat_o <= TIMEOUT_DATA;
                        bus.wbs_ack_o <= 1'b1;
                        bus.s_cyc_o   <= 3'b000;
                        state         <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_user_wb_slave_arbiter.sv
// Directed bench for user_wb_slave_arbiter: per-cycle vector table plus
// hand sequences for watchdog, saturation and reset-in-flight.
module tb_user_wb_slave_arbiter;

    localparam logic [95:0] D_A = {32'h1234_5678, 32'h5555_1111, 32'hAAAA_0000};
    localparam logic [95:0] D_B = {32'h0BAD_F00D, 32'hCAFE_0001, 32'h0000_C0DE};

    logic       clk = 1'b0;
    logic       rst;
    logic       timeout_flag;
    logic [7:0] timeout_cnt;
    int         checks   = 0;
    int         failures = 0;

    user_wb_slave_arbiter_if bus();

    user_wb_slave_arbiter dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .bus          (bus),
        .timeout_flag (timeout_flag),
        .timeout_cnt  (timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [2:0]  sack;
        logic [95:0] sdat;
        logic        exp_ack;
        logic [2:0]  exp_scyc;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vt[30];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [2:0] k,
                         input logic [95:0] d);
        bus.wbs_cyc_i = c;
        bus.wbs_stb_i = s;
        bus.wbs_we_i  = w;
        bus.wbs_adr_i = a;
        bus.s_ack_i   = k;
        bus.s_dat_i   = d;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One request with no slave response; returns edges from request to ack.
    task automatic run_timeout(output int lat, output logic [31:0] d);
        lat = -1;
        d   = 32'h0;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, 3'b000, D_A);
        step();
        for (int n = 1; n <= 40; n++) begin
            step();
            if (bus.wbs_ack_o === 1'b1) begin
                lat = n;
                d   = bus.wbs_dat_o;
                break;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, D_A);
        step();
    endtask

    initial begin
        int          lat;
        int          bad;
        int          seen;
        logic [31:0] d;

        vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h300F_FFF8, 3'b000, D_A, 1'b0, 3'b100, 32'h0000_0000};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h300F_FFF8, 3'b000, D_A, 1'b0, 3'b100, 32'h0000_0000};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 32'h300F_FFF8, 3'b000, D_A, 1'b0, 3'b100, 32'h0000_0000};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 32'h300F_FFF8, 3'b100, D_A, 1'b1, 3'b000, 32'h1234_5678};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b000, D_A, 1'b0, 3'b000, 32'h1234_5678};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h3000_0010, 3'b000, D_A, 1'b0, 3'b010, 32'h1234_5678};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h3000_0010, 3'b010, D_A, 1'b1, 3'b000, 32'h5555_1111};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h3001_0000, 3'b000, D_A, 1'b0, 3'b000, 32'h5555_1111};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h3001_0000, 3'b000, D_A, 1'b0, 3'b001, 32'h5555_1111};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 32'h3001_0000, 3'b001, D_A, 1'b1, 3'b000, 32'hAAAA_0000};
        vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b000, D_A, 1'b0, 3'b000, 32'hAAAA_0000};
        vt[11] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 3'b000, D_B, 1'b0, 3'b001, 32'hAAAA_0000};
        vt[12] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 3'b100, D_B, 1'b0, 3'b001, 32'hAAAA_0000};
        vt[13] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 3'b110, D_B, 1'b0, 3'b001, 32'hAAAA_0000};
        vt[14] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 3'b001, D_B, 1'b1, 3'b000, 32'h0000_C0DE};
        vt[15] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b000, D_B, 1'b0, 3'b000, 32'h0000_C0DE};
        vt[16] = '{1'b1, 1'b1, 1'b1, 32'h3000_0020, 3'b000, D_A, 1'b0, 3'b010, 32'h0000_C0DE};
        vt[17] = '{1'b1, 1'b1, 1'b1, 32'h3000_0020, 3'b000, D_A, 1'b0, 3'b010, 32'h0000_C0DE};
        vt[18] = '{1'b0, 1'b1, 1'b1, 32'h3000_0020, 3'b010, D_A, 1'b0, 3'b000, 32'h0000_C0DE};
        vt[19] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b000, D_A, 1'b0, 3'b000, 32'h0000_C0DE};
        vt[20] = '{1'b1, 1'b1, 1'b1, 32'h300F_FFFC, 3'b000, D_A, 1'b0, 3'b100, 32'h0000_C0DE};
        vt[21] = '{1'b1, 1'b1, 1'b1, 32'h300F_FFFC, 3'b111, D_A, 1'b1, 3'b000, 32'h1234_5678};
        vt[22] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b000, D_A, 1'b0, 3'b000, 32'h1234_5678};
        vt[23] = '{1'b1, 1'b1, 1'b0, 32'h3000_0FFC, 3'b000, D_B, 1'b0, 3'b010, 32'h1234_5678};
        vt[24] = '{1'b1, 1'b1, 1'b0, 32'h3000_0FFC, 3'b010, D_B, 1'b1, 3'b000, 32'hCAFE_0001};
        vt[25] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b000, D_B, 1'b0, 3'b000, 32'hCAFE_0001};
        vt[26] = '{1'b1, 1'b1, 1'b0, 32'h300F_FFF0, 3'b000, D_A, 1'b0, 3'b001, 32'hCAFE_0001};
        vt[27] = '{1'b1, 1'b1, 1'b0, 32'h300F_FFF0, 3'b001, D_A, 1'b1, 3'b000, 32'hAAAA_0000};
        vt[28] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b000, D_A, 1'b0, 3'b000, 32'hAAAA_0000};
        vt[29] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 3'b000, D_A, 1'b0, 3'b000, 32'hAAAA_0000};

        rst           = 1'b1;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_dat_i = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, D_A);
        step();
        step();
        chk("rst_ack",   32'(bus.wbs_ack_o),  32'h0);
        chk("rst_scyc",  32'(bus.s_cyc_o),    32'h0);
        chk("rst_dat",   bus.wbs_dat_o,       32'h0);
        chk("rst_flag",  32'(timeout_flag),   32'h0);
        chk("rst_tcnt",  32'(timeout_cnt),    32'h0);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            drive(vt[i].cyc, vt[i].stb, vt[i].we, vt[i].adr, vt[i].sack, vt[i].sdat);
            step();
            chk($sformatf("v%0d_ack", i),  32'(bus.wbs_ack_o), 32'(vt[i].exp_ack));
            chk($sformatf("v%0d_scyc", i), 32'(bus.s_cyc_o),   32'(vt[i].exp_scyc));
            chk($sformatf("v%0d_dat", i),  bus.wbs_dat_o,      vt[i].exp_dat);
            chk($sformatf("v%0d_flag", i), 32'(timeout_flag),  32'h0);
        end

`ifdef WB_TIMEOUT_EN
        run_timeout(lat, d);
        chk("to_latency", 32'(lat), 32'd16);
        chk("to_data",    d,        32'hDEAD_BEEF);
        chk("to_flag",    32'(timeout_flag), 32'h1);
        chk("to_cnt1",    32'(timeout_cnt),  32'h1);

        // Slave ack lands exactly on the expiry edge.
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, 3'b000, D_B);
        step();
        seen = 0;
        for (int n = 0; n < 15; n++) begin
            step();
            if (bus.wbs_ack_o === 1'b1) seen++;
        end
        chk("race_early_ack", 32'(seen), 32'h0);
        bus.s_ack_i = 3'b001;
        step();
        chk("race_ack",  32'(bus.wbs_ack_o), 32'h1);
        chk("race_dat",  bus.wbs_dat_o,      32'h0000_C0DE);
        chk("race_cnt",  32'(timeout_cnt),   32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, D_A);
        step();

        bad = 0;
        for (int n = 0; n < 299; n++) begin
            run_timeout(lat, d);
            if (lat != 16 || d !== 32'hDEAD_BEEF) bad++;
        end
        chk("sat_bad_runs", 32'(bad),          32'h0);
        chk("sat_cnt",      32'(timeout_cnt),  32'hFF);
        chk("sat_flag",     32'(timeout_flag), 32'h1);
`else
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, 3'b000, D_A);
        step();
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (bus.wbs_ack_o === 1'b1) seen++;
        end
        chk("nowd_ack",  32'(seen),         32'h0);
        chk("nowd_scyc", 32'(bus.s_cyc_o),  32'h1);
        chk("nowd_flag", 32'(timeout_flag), 32'h0);
        chk("nowd_tcnt", 32'(timeout_cnt),  32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, D_A);
        step();
        chk("nowd_abort_scyc", 32'(bus.s_cyc_o), 32'h0);
`endif

        // Reset while BUSY, with the selected slave acking in the same cycle.
        drive(1'b1, 1'b1, 1'b0, 32'h3000_0100, 3'b000, D_A);
        step();
        chk("mid_busy_scyc", 32'(bus.s_cyc_o), 32'h2);
        rst         = 1'b1;
        bus.s_ack_i = 3'b010;
        step();
        chk("mid_rst_ack",  32'(bus.wbs_ack_o), 32'h0);
        chk("mid_rst_scyc", 32'(bus.s_cyc_o),   32'h0);
        chk("mid_rst_flag", 32'(timeout_flag),  32'h0);
        chk("mid_rst_tcnt", 32'(timeout_cnt),   32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, D_A);
        step();
        chk("post_rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h3000_0100, 3'b000, D_B);
        step();
        bus.s_ack_i = 3'b010;
        step();
        chk("post_rst_req_ack", 32'(bus.wbs_ack_o), 32'h1);
        chk("post_rst_req_dat", bus.wbs_dat_o,      32'hCAFE_0001);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, D_A);
        step();
        chk("post_rst_ack_single", 32'(bus.wbs_ack_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
